// File: rtl/zbt_arbiter_if.sv
// Bus bundle between the ZBT arbiter, its three requesters and the ZBT SRAM.
// The arbiter connects through the slave modport; the requester/memory side
// (or a bench standing in for it) uses the master modport.
interface zbt_arbiter_if;
  logic        disp_req;
  logic [18:0] disp_addr;
  logic        disp_ack;
  logic        disp_valid;
  logic [35:0] disp_data;

  logic        cap_req;
  logic [18:0] cap_addr;
  logic [35:0] cap_data;
  logic        cap_ack;

  logic        proc_req;
  logic        proc_we;
  logic [18:0] proc_addr;
  logic [35:0] proc_wdata;
  logic        proc_ack;
  logic        proc_valid;
  logic [35:0] proc_rdata;

  logic        mem_wr;
  logic [18:0] mem_addr;
  logic [35:0] mem_write;
  logic [35:0] mem_read;

  modport slave (
    input  disp_req, disp_addr,
    input  cap_req, cap_addr, cap_data,
    input  proc_req, proc_we, proc_addr, proc_wdata,
    input  mem_read,
    output disp_ack, disp_valid, disp_data,
    output cap_ack,
    output proc_ack, proc_valid, proc_rdata,
    output mem_wr, mem_addr, mem_write
  );

  modport master (
    output disp_req, disp_addr,
    output cap_req, cap_addr, cap_data,
    output proc_req, proc_we, proc_addr, proc_wdata,
    output mem_read,
    input  disp_ack, disp_valid, disp_data,
    input  cap_ack,
    input  proc_ack, proc_valid, proc_rdata,
    input  mem_wr, mem_addr, mem_write
  );
endinterface

// File: rtl/zbt_arbiter.sv
// Three-way arbiter (display read, capture write, processor read/write) in
// front of a single ZBT SRAM port. Fixed priority disp > cap > proc, with a
// wait counter that forces a processor grant once it has waited STARVE_LIMIT
// cycles. Granted requests reach the SRAM one cycle later; read data returns
// three cycles after the grant and is steered by a 3-deep owner tag pipeline.
module zbt_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clock,
  input  logic          reset,
  zbt_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_PROC = 2'd2
  } owner_e;

  logic        grant_disp_s;
  logic        grant_cap_s;
  logic        grant_proc_s;
  logic        starve_s;

  logic [3:0]  wait_q, wait_d;
  owner_e      tag1_q, tag1_d;
  owner_e      tag2_q;
  owner_e      tag3_q;
  logic        mem_wr_q, mem_wr_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic [35:0] mem_write_q, mem_write_d;
  logic [35:0] disp_data_q, disp_data_d;
  logic [35:0] proc_rdata_q, proc_rdata_d;

  // Pick at most one winner this cycle; a starved processor overrides priority.
  always_comb begin
    grant_disp_s = 1'b0;
    grant_cap_s  = 1'b0;
    grant_proc_s = 1'b0;
    starve_s     = bus.proc_req && (wait_q == LIMIT);
    if (reset) begin
      grant_proc_s = 1'b0;
    end else if (starve_s) begin
      grant_proc_s = 1'b1;
    end else if (bus.disp_req) begin
      grant_disp_s = 1'b1;
    end else if (bus.cap_req) begin
      grant_cap_s = 1'b1;
    end else if (bus.proc_req) begin
      grant_proc_s = 1'b1;
    end else begin
      grant_proc_s = 1'b0;
    end
  end

  // Next-state: wait counter, SRAM command for the winner, read tag, data holds.
  always_comb begin
    wait_d       = wait_q;
    mem_wr_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_write_d  = mem_write_q;
    tag1_d       = OWN_NONE;
    disp_data_d  = disp_data_q;
    proc_rdata_d = proc_rdata_q;

    if (!bus.proc_req || grant_proc_s) begin
      wait_d = 4'd0;
    end else if (wait_q < LIMIT) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end

    if (grant_disp_s) begin
      mem_addr_d = bus.disp_addr;
      tag1_d     = OWN_DISP;
    end else if (grant_cap_s) begin
      mem_addr_d  = bus.cap_addr;
      mem_wr_d    = 1'b1;
      mem_write_d = bus.cap_data;
    end else if (grant_proc_s) begin
      mem_addr_d  = bus.proc_addr;
      mem_wr_d    = bus.proc_we;
      mem_write_d = bus.proc_wdata;
      tag1_d      = bus.proc_we ? OWN_NONE : OWN_PROC;
    end else begin
      mem_wr_d = 1'b0;
    end

    // Capture returning data so the output holds it once the strobe drops.
    if (tag3_q == OWN_DISP) begin
      disp_data_d = bus.mem_read;
    end else if (tag3_q == OWN_PROC) begin
      proc_rdata_d = bus.mem_read;
    end else begin
      disp_data_d = disp_data_q;
    end
  end

  // State registers with synchronous reset; reset also discards in-flight reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q       <= 4'd0;
      tag1_q       <= OWN_NONE;
      tag2_q       <= OWN_NONE;
      tag3_q       <= OWN_NONE;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= 19'd0;
      mem_write_q  <= 36'd0;
      disp_data_q  <= 36'd0;
      proc_rdata_q <= 36'd0;
    end else begin
      wait_q       <= wait_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag1_q;
      tag3_q       <= tag2_q;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_write_q  <= mem_write_d;
      disp_data_q  <= disp_data_d;
      proc_rdata_q <= proc_rdata_d;
    end
  end

  // Outputs are forced to zero for the whole time reset is high, including
  // its first cycle, before the synchronous clear has taken effect.
  assign bus.disp_ack   = grant_disp_s;
  assign bus.cap_ack    = grant_cap_s;
  assign bus.proc_ack   = grant_proc_s;
  assign bus.mem_wr     = mem_wr_q & ~reset;
  assign bus.mem_addr   = reset ? 19'd0 : mem_addr_q;
  assign bus.mem_write  = reset ? 36'd0 : mem_write_q;
  assign bus.disp_valid = ~reset && (tag3_q == OWN_DISP);
  assign bus.proc_valid = ~reset && (tag3_q == OWN_PROC);
  assign bus.disp_data  = reset ? 36'd0 : (bus.disp_valid ? bus.mem_read : disp_data_q);
  assign bus.proc_rdata = reset ? 36'd0 : (bus.proc_valid ? bus.mem_read : proc_rdata_q);

endmodule

// File: tb/tb_zbt_arbiter.sv
// Scoreboard bench for zbt_arbiter: a per-cycle reference model predicts grants,
// SRAM commands and read returns from the arbitration rules; a monitor pops and
// compares whatever the DUT presents. The SRAM itself is a simple 2-cycle model.
module tb_zbt_arbiter;
  localparam int LIMIT = 8;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  zbt_arbiter_if bus ();

  zbt_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // ZBT SRAM: write commits at the clock edge; read data appears two cycles
  // after the address is presented.
  logic [35:0] zbt_mem [logic [18:0]];
  logic [35:0] rd_stage;
  always @(posedge clock) begin
    if (bus.mem_wr === 1'b1) zbt_mem[bus.mem_addr] = bus.mem_write;
    if (reset) rd_stage <= 36'd0;
    else rd_stage <= zbt_mem.exists(bus.mem_addr) ? zbt_mem[bus.mem_addr] : 36'd0;
    bus.mem_read <= rd_stage;
  end

  typedef struct { int due; bit is_disp; logic [35:0] data; } rd_t;
  typedef struct { int due; bit wr; logic [18:0] addr; logic [35:0] data; } mem_t;
  rd_t  rd_q[$];
  mem_t mem_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: arbitration rules, starvation counter, memory contents.
  logic [35:0] ref_mem [logic [18:0]];
  int          m_wait = 0;
  bit          pend_wr = 1'b0;
  logic [18:0] pend_addr;
  logic [35:0] pend_data;

  function automatic logic [35:0] ref_read(input logic [18:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 36'd0;
  endfunction

  always @(negedge clock) begin
    bit gd, gc, gp;
    if (reset) begin
      m_wait  = 0;
      pend_wr = 1'b0;
      rd_q.delete();
      mem_q.delete();
      check("ack_in_reset", {61'd0, bus.disp_ack, bus.cap_ack, bus.proc_ack}, 64'd0);
    end else begin
      if (pend_wr) ref_mem[pend_addr] = pend_data;
      pend_wr = 1'b0;
      gd = 1'b0; gc = 1'b0; gp = 1'b0;
      if (bus.proc_req && m_wait == LIMIT) gp = 1'b1;
      else if (bus.disp_req) gd = 1'b1;
      else if (bus.cap_req) gc = 1'b1;
      else if (bus.proc_req) gp = 1'b1;
      check("acks", {61'd0, bus.disp_ack, bus.cap_ack, bus.proc_ack}, {61'd0, gd, gc, gp});
      if (gd) begin
        rd_q.push_back('{cyc + 3, 1'b1, ref_read(bus.disp_addr)});
        mem_q.push_back('{cyc + 1, 1'b0, bus.disp_addr, 36'd0});
      end
      if (gc) begin
        pend_wr = 1'b1; pend_addr = bus.cap_addr; pend_data = bus.cap_data;
        mem_q.push_back('{cyc + 1, 1'b1, bus.cap_addr, bus.cap_data});
      end
      if (gp && bus.proc_we) begin
        pend_wr = 1'b1; pend_addr = bus.proc_addr; pend_data = bus.proc_wdata;
        mem_q.push_back('{cyc + 1, 1'b1, bus.proc_addr, bus.proc_wdata});
      end
      if (gp && !bus.proc_we) begin
        rd_q.push_back('{cyc + 3, 1'b0, ref_read(bus.proc_addr)});
        mem_q.push_back('{cyc + 1, 1'b0, bus.proc_addr, 36'd0});
      end
      if (!bus.proc_req || gp) m_wait = 0;
      else if (m_wait < LIMIT) m_wait++;
    end
  end

  // Monitor: compares SRAM commands and read strobes against the queues.
  logic [18:0] last_addr = 19'd0;
  logic [35:0] last_dd = 36'd0;
  logic [35:0] last_pd = 36'd0;
  always @(negedge clock) begin
    mem_t m;
    rd_t  r;
    if (reset) begin
      check("outs_in_reset", {58'd0, bus.disp_valid, bus.proc_valid, bus.mem_wr,
            |bus.mem_addr, |bus.mem_write, |{bus.disp_data, bus.proc_rdata}}, 64'd0);
      last_addr = 19'd0; last_dd = 36'd0; last_pd = 36'd0;
    end else begin
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
        m = mem_q.pop_front();
        check("mem_wr", {63'd0, bus.mem_wr}, {63'd0, m.wr});
        check("mem_addr", {45'd0, bus.mem_addr}, {45'd0, m.addr});
        if (m.wr) check("mem_write", {28'd0, bus.mem_write}, {28'd0, m.data});
        last_addr = m.addr;
      end else begin
        check("mem_wr_idle", {63'd0, bus.mem_wr}, 64'd0);
        check("mem_addr_hold", {45'd0, bus.mem_addr}, {45'd0, last_addr});
      end
      if (rd_q.size() > 0 && rd_q[0].due < cyc) begin
        r = rd_q.pop_front();
        check("missing_valid", 64'(r.due), 64'(cyc));
      end
      if (bus.disp_valid || bus.proc_valid) begin
        if (rd_q.size() == 0) begin
          check("unexpected_valid", {62'd0, bus.disp_valid, bus.proc_valid}, 64'd0);
        end else begin
          r = rd_q.pop_front();
          check("valid_cycle", 64'(cyc), 64'(r.due));
          check("valid_owner", {62'd0, bus.disp_valid, bus.proc_valid},
                r.is_disp ? 64'd2 : 64'd1);
          check("rdata", {28'd0, r.is_disp ? bus.disp_data : bus.proc_rdata}, {28'd0, r.data});
          if (r.is_disp) last_dd = r.data;
          else last_pd = r.data;
        end
      end else begin
        check("disp_hold", {28'd0, bus.disp_data}, {28'd0, last_dd});
        check("proc_hold", {28'd0, bus.proc_rdata}, {28'd0, last_pd});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.disp_req = 1'b0;
    bus.cap_req  = 1'b0;
    bus.proc_req = 1'b0;
    bus.proc_we  = 1'b0;
  endtask

  function automatic logic [35:0] rnd36();
    return {4'($urandom_range(0, 15)), 32'($urandom)};
  endfunction

  task automatic rand_cycle();
    if (!bus.disp_req || $urandom_range(0, 3) == 0) begin
      bus.disp_req  = 1'($urandom_range(0, 1));
      bus.disp_addr = 19'($urandom_range(0, 7));
    end
    if (!bus.cap_req || $urandom_range(0, 3) == 0) begin
      bus.cap_req  = 1'($urandom_range(0, 1));
      bus.cap_addr = 19'($urandom_range(0, 7));
      bus.cap_data = rnd36();
    end
    if (!bus.proc_req || $urandom_range(0, 7) == 0) begin
      bus.proc_req   = 1'($urandom_range(0, 1));
      bus.proc_we    = 1'($urandom_range(0, 1));
      bus.proc_addr  = 19'($urandom_range(0, 7));
      bus.proc_wdata = rnd36();
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    bus.disp_addr = 19'd0; bus.cap_addr = 19'd0; bus.cap_data = 36'd0;
    bus.proc_addr = 19'd0; bus.proc_wdata = 36'd0;
    repeat (3) step();
    reset = 1'b0;

    // Capture write then display read of the same address.
    bus.cap_req = 1'b1; bus.cap_addr = 19'h00010; bus.cap_data = 36'h123;
    step(); idle();
    step();
    bus.disp_req = 1'b1; bus.disp_addr = 19'h00010;
    step(); idle();
    repeat (4) step();

    // All three requesting: starvation forces a processor grant.
    bus.disp_req = 1'b1; bus.disp_addr = 19'h1;
    bus.cap_req = 1'b1; bus.cap_addr = 19'h2; bus.cap_data = 36'hABC;
    bus.proc_req = 1'b1; bus.proc_we = 1'b0; bus.proc_addr = 19'h10;
    repeat (20) step();
    idle();
    repeat (4) step();

    // Capture versus processor write.
    bus.cap_req = 1'b1; bus.cap_addr = 19'h3; bus.cap_data = 36'h555;
    bus.proc_req = 1'b1; bus.proc_we = 1'b1; bus.proc_addr = 19'h4; bus.proc_wdata = 36'hF_0000_0001;
    repeat (12) step();
    idle();
    step();

    // Back-to-back alternating reads.
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i % 2 == 0) begin bus.disp_req = 1'b1; bus.disp_addr = 19'(i % 5); end
      else begin bus.proc_req = 1'b1; bus.proc_addr = 19'h4; end
      step();
    end
    idle();
    repeat (5) step();

    // Reset right after a processor read grant discards the read.
    bus.proc_req = 1'b1; bus.proc_we = 1'b0; bus.proc_addr = 19'h10;
    step(); idle();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      rand_cycle();
      step();
    end
    reset = 1'b0;
    idle();
    repeat (8) step();
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
